ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. keyboard LED set 0xED, mouse enable 0xF4) to a keyboard or mouse.
- Counterpart of the existing PS/2 receive path in the controller, which reads device-to-host frames on the same two lines.
- Drives the open-drain clock/data pins through pull-low enables.
- `busy` gates the receiver, so the device's ACK bit and any response are not mis-framed while a transmit is in progress.

Parameters:
- INHIBIT, 2800: system clocks the PS/2 clock is held low before request-to-send (100 us at 28 MHz).
- TIMEOUT, 420000: system clocks allowed between consecutive device clock falling edges, or before the line goes idle, before aborting (15 ms at 28 MHz).
- FILTER, 8: number of consecutive equal synchronised samples needed to accept a PS/2 clock level change.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- strb  input  1  one-cycle request to send `data`
- data  input  8  command byte, sampled on the `strb` cycle
- busy  output  1  high from the cycle after an accepted `strb` until `done`
- done  output  1  one-cycle pulse at end of transaction
- err  output  1  valid with `done`: 1 = NACK or timeout; held until next accepted `strb`
- ps2CkI  input  1  PS/2 clock pin level
- ps2DI  input  1  PS/2 data pin level
- ps2CkOe  output  1  1 = pull PS/2 clock low
- ps2DOe  output  1  1 = pull PS/2 data low

Behaviour:
- Input conditioning:
  - ps2CkI and ps2DI each pass through a 2-FF synchroniser.
  - Clock level accepted only after FILTER equal samples; glitches shorter than FILTER are ignored.
  - Falling edge (`fall`) = accepted level goes 1->0.
- Reset (any state, including mid-frame): state=IDLE; ps2CkOe=0, ps2DOe=0, busy=0, done=0, err=0. Lines are released on the next clock edge.
- Transmit latch: accepted `strb` loads shift register {stop=1, parity, data[7:0]}. Parity is odd: parity = ~^data.
- State machine:
  - IDLE: ps2CkOe=0, ps2DOe=0. On strb -> INHIBIT; counter=0; busy=1; err=0.
  - INHIBIT: ps2CkOe=1. When counter reaches INHIBIT-1 -> RTS.
  - RTS: for one cycle ps2DOe=1 (start bit 0), ps2CkOe=0. Watchdog=0, bitcnt=0 -> SEND.
  - SEND:
    - On each `fall`: ps2DOe = ~shift[bitcnt]; bitcnt++; watchdog=0.
    - Falls 1-8 present data bits 0-7, LSB first; fall 9 presents parity; fall 10 presents stop (ps2DOe=0, line released).
    - After fall 10 -> ACK.
  - ACK: ps2DOe=0. On next `fall`, sample synchronised data: 0 = ACK (err stays 0), 1 = NACK (err=1). Then -> WAITIDLE.
  - WAITIDLE: when filtered clock=1 and data=1 -> IDLE; done=1; busy=0.
- Watchdog:
  - Counts in SEND, ACK and WAITIDLE; cleared on each `fall`.
  - On reaching TIMEOUT-1: release both lines, err=1, done=1, busy=0 -> IDLE.
- strb while busy: ignored; no queueing, no effect on the current frame.
- strb in the same cycle as done: ignored. A new request is accepted only when busy=0 at strb.
- Simultaneous reset and strb: reset wins.
- Latency, strb to first line activity: 1 cycle to ps2CkOe=1. RTS is reached INHIBIT cycles later.

Test Plan:
- Send 0xED to a device model that clocks at 12.5 kHz and ACKs:
  - Bits seen at device rising edges: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK is sampled; done=1 with err=0; busy high throughout; ps2CkOe low held for exactly INHIBIT cycles.
- Send 0xF4 with a device model that NACKs (data high at the 11th fall):
  - Parity bit presented = 0.
  - Result: done=1, err=1; both Oe=0 after done.
- No device connected (clock stays high after RTS):
  - done=1, err=1 exactly TIMEOUT cycles after RTS; ps2CkOe=0 and ps2DOe=0 from then on.
- Reset asserted at fall 5 of a frame:
  - Next cycle: ps2CkOe=0, ps2DOe=0, busy=0, done=0, err=0.
  - A following strb with 0xF4 completes normally with err=0.
- Second strb (0xAA) issued during SEND of 0xED: ignored; the frame on the wire is 0xED only, with one done pulse.
- 3-cycle low glitch on ps2CkI during SEND (FILTER=8): no bit advance; the frame completes with correct bits and err=0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then shifts one
// command byte with odd parity and stop bit out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT = 2800,
  parameter int unsigned TIMEOUT = 420000,
  parameter int unsigned FILTER  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2CkI,
  input  logic       ps2DI,
  output logic       ps2CkOe,
  output logic       ps2DOe
);

  localparam int unsigned IW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_RTS      = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAITIDLE = 3'd5;

  logic          r_ck_s1, r_ck_s2, r_d_s1, r_d_s2;
  logic          r_ck_filt;
  logic [FW-1:0] r_flt_cnt;
  logic [2:0]    r_state;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_wd_cnt;
  logic [3:0]    r_bitcnt;
  logic [9:0]    r_shift;
  logic          r_ck_oe, r_d_oe, r_busy, r_done, r_err;
  logic          w_fall;
  logic          w_wd_active;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ck_s1   <= 1'b1;
      r_ck_s2   <= 1'b1;
      r_d_s1    <= 1'b1;
      r_d_s2    <= 1'b1;
      r_ck_filt <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_ck_s1 <= ps2CkI;
      r_ck_s2 <= r_ck_s1;
      r_d_s1  <= ps2DI;
      r_d_s2  <= r_d_s1;
      // Level flips only after FILTER consecutive samples disagree with it.
      if (r_ck_s2 == r_ck_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FW'(FILTER - 1)) begin
        r_ck_filt <= r_ck_s2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  assign w_fall      = r_ck_filt & ~r_ck_s2 & (r_flt_cnt == FW'(FILTER - 1));
  assign w_wd_active = (r_state == S_RTS) || (r_state == S_SEND) ||
                       (r_state == S_ACK) || (r_state == S_WAITIDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_inh_cnt <= '0;
      r_wd_cnt  <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ck_oe   <= 1'b0;
      r_d_oe    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ck_oe <= 1'b0;
          r_d_oe  <= 1'b0;
          // A strobe coinciding with the done pulse is dropped.
          if (strb && !r_done) begin
            r_state   <= S_INHIBIT;
            r_inh_cnt <= '0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_ck_oe   <= 1'b1;
            r_shift   <= {1'b1, ~^data, data};
          end
        end
        S_INHIBIT: begin
          if (r_inh_cnt == IW'(INHIBIT - 1)) begin
            r_state  <= S_RTS;
            r_ck_oe  <= 1'b0;
            r_d_oe   <= 1'b1;
            r_wd_cnt <= '0;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        S_RTS: begin
          r_bitcnt <= '0;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_fall) begin
            r_d_oe   <= ~r_shift[0];
            r_shift  <= {1'b1, r_shift[9:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 4'd9) r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_d_oe <= 1'b0;
          if (w_fall) begin
            r_err   <= r_d_s2;
            r_state <= S_WAITIDLE;
          end
        end
        S_WAITIDLE: begin
          if (r_ck_filt && r_d_s2) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wd_active) begin
        if (r_wd_cnt == TW'(TIMEOUT - 1)) begin
          r_state <= S_IDLE;
          r_ck_oe <= 1'b0;
          r_d_oe  <= 1'b0;
          r_err   <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end else if (w_fall) begin
          r_wd_cnt <= '0;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign ps2CkOe = r_ck_oe;
  assign ps2DOe  = r_d_oe;

endmodule
